// File: rtl/pwm_audio_out_if.sv
// Sample stream from the lowpass filter into the PWM audio stage.
// Transfer on any rising clk edge where in_valid & in_ready.
interface pwm_audio_out_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pwm_audio_out.sv
// One-entry buffered PWM audio output: each sample plays for REPEAT periods of 2**PWM_BITS clocks.
// Optional build macro PWM_DITHER_EN adds LFSR dither ahead of the duty truncation.
module pwm_audio_out #(
  parameter int DATA_W   = 16,
  parameter int PWM_BITS = 8,
  parameter int REPEAT   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  pwm_audio_out_if.slave  s,
  output logic            pwm_out,
  output logic            sample_tick,
  output logic            underrun
);

  localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [REP_W-1:0]    REP_LAST = REP_W'(REPEAT - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [REP_W-1:0]    rep_cnt;
  logic [PWM_BITS-1:0] duty;
  logic [DATA_W-1:0]   sample_buf;
  logic                buf_full;
  logic                live;       // low only until the first clock after reset
  logic                period_end;
  logic                frame_end;
  logic                accept;
  logic [PWM_BITS-1:0] next_duty;

  assign period_end = en && (pwm_cnt == CNT_MAX);
  assign frame_end  = period_end && (rep_cnt == REP_LAST);
  assign s.in_ready = en & live & ~buf_full;
  assign accept     = s.in_valid & s.in_ready;

`ifdef PWM_DITHER_EN
  localparam int DITH_W = DATA_W - PWM_BITS;

  logic [15:0]       lfsr;
  logic [DATA_W:0]   dith_sum;
  logic [DATA_W-1:0] dith_sat;

  // Dither lives below the duty LSB; saturate so full scale never wraps to silence.
  always_comb begin
    dith_sum = {1'b0, sample_buf} + {{(DATA_W + 1 - DITH_W){1'b0}}, lfsr[DITH_W-1:0]};
    dith_sat = dith_sum[DATA_W] ? '1 : dith_sum[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (frame_end) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign next_duty = dith_sat[DATA_W-1 -: PWM_BITS];
`else
  logic unused_buf_lsbs;

  assign unused_buf_lsbs = ^sample_buf[DATA_W-PWM_BITS-1:0];
  assign next_duty       = sample_buf[DATA_W-1 -: PWM_BITS];
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt     <= '0;
      rep_cnt     <= '0;
      duty        <= '0;
      // NOTE: the sample buffer is reset too; a discarded sample must never
      // reach the pin, and the flop count is small enough not to matter.
      sample_buf  <= '0;
      buf_full    <= 1'b0;
      live        <= 1'b0;
      pwm_out     <= 1'b0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      live        <= 1'b1;
      sample_tick <= frame_end;
      underrun    <= frame_end & ~buf_full;
      pwm_out     <= en & (pwm_cnt < duty);

      if (!en) begin
        pwm_cnt <= '0;
        rep_cnt <= '0;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
        if (period_end) begin
          rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + 1'b1;
        end
      end

      // A full buffer blocks in_ready, so load and accept never collide.
      if (frame_end && buf_full) begin
        duty     <= next_duty;
        buf_full <= 1'b0;
      end else if (accept) begin
        sample_buf <= s.in_data;
        buf_full   <= 1'b1;
      end
    end
  end

  a_underrun_on_tick : assert property (@(posedge clk) disable iff (rst)
    underrun |-> sample_tick);

  a_quiet_when_disabled : assert property (@(posedge clk) disable iff (rst)
    !en |=> (!pwm_out && !sample_tick && !underrun));

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out at DATA_W=16, PWM_BITS=8, REPEAT=4 (1024-clock frames).
// Frames are measured from the sample_tick cycle; the pwm_cnt=255 slot is always low, so highs = 4*duty.
module tb_pwm_audio_out;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic pwm_out;
  logic sample_tick;
  logic underrun;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_audio_out_if #(.DATA_W(16)) sif ();

  pwm_audio_out #(.DATA_W(16), .PWM_BITS(8), .REPEAT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .s           (sif.slave),
    .pwm_out     (pwm_out),
    .sample_tick (sample_tick),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // Returns the number of negedges until sample_tick is seen, or -1 on timeout.
  task automatic wait_tick(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 2100; i++) begin
      @(negedge clk);
      if (sample_tick === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Call at the tick negedge; returns at the last negedge of the frame.
  task automatic measure(output int highs, output bit uniform, output int ticks, output int unders);
    int per [4];
    per    = '{default: 0};
    ticks  = 0;
    unders = 0;
    for (int k = 0; k < 1024; k++) begin
      if (k > 0) @(negedge clk);
      per[k / 256] += int'(pwm_out === 1'b1);
      ticks        += int'(sample_tick === 1'b1);
      unders       += int'(underrun === 1'b1);
    end
    highs   = per[0] + per[1] + per[2] + per[3];
    uniform = (per[0] == per[1]) && (per[1] == per[2]) && (per[2] == per[3]);
  endtask

  // Call at a negedge; returns at the negedge after the transfer edge.
  task automatic push(input logic [15:0] d, output bit ok);
    sif.in_data  = d;
    sif.in_valid = 1'b1;
    ok           = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      if (sif.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    sif.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    en           = 1'b1;
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL reset_pwm_out: got %b want 0", pwm_out); end
    n_cmp++; if (sif.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", sif.in_ready); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    n_cmp++; if (sample_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", sample_tick); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (sif.in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", sif.in_ready); end
  endtask

  task automatic test_half_scale();
    bit ok, ok2, uni;
    int cyc, h, t, un;
    push(16'h8000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL half_push: accepted %b want 1", ok); end
    wait_tick(cyc);
    n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL half_first_tick: waited %0d want tick", cyc); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL half_no_underrun: got %b want 0", underrun); end
    fork
      measure(h, uni, t, un);
      push(16'h8000, ok2);
    join
    n_cmp++; if (h != 512) begin n_bad++; $display("FAIL half_highs: got %0d want 512", h); end
    n_cmp++; if (!uni) begin n_bad++; $display("FAIL half_uniform: got %b want 1", uni); end
    n_cmp++; if (t != 1) begin n_bad++; $display("FAIL half_ticks_in_frame: got %0d want 1", t); end
    n_cmp++; if (!ok2) begin n_bad++; $display("FAIL half_second_push: accepted %b want 1", ok2); end
    wait_tick(cyc);
    n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL tick_period: next tick after %0d want 1 (1024 clocks)", cyc); end
  endtask

  task automatic test_zero_full();
    bit ok, uni;
    int cyc, h, t, un;
    fork
      measure(h, uni, t, un);
      push(16'h0000, ok);
    join
    n_cmp++; if (h != 512) begin n_bad++; $display("FAIL repeat_half_highs: got %0d want 512", h); end
    wait_tick(cyc);
    fork
      measure(h, uni, t, un);
      push(16'hFFFF, ok);
    join
    n_cmp++; if (h != 0) begin n_bad++; $display("FAIL zero_highs: got %0d want 0", h); end
    n_cmp++; if (un != 0) begin n_bad++; $display("FAIL zero_underrun: got %0d want 0", un); end
    wait_tick(cyc);
    fork
      measure(h, uni, t, un);
      push(16'h4000, ok);
    join
    n_cmp++; if (h != 1020) begin n_bad++; $display("FAIL full_highs: got %0d want 1020", h); end
    n_cmp++; if (!uni) begin n_bad++; $display("FAIL full_uniform: got %b want 1 (255 per period)", uni); end
  endtask

  task automatic test_underrun();
    bit uni;
    int cyc, h, t, un;
    wait_tick(cyc);
    measure(h, uni, t, un);
    n_cmp++; if (h != 256) begin n_bad++; $display("FAIL quarter_highs: got %0d want 256", h); end
    n_cmp++; if (un != 0) begin n_bad++; $display("FAIL quarter_underrun: got %0d want 0", un); end
    wait_tick(cyc);
    measure(h, uni, t, un);
    n_cmp++; if (un != 1) begin n_bad++; $display("FAIL underrun_count: got %0d want 1", un); end
    n_cmp++; if (h != 256) begin n_bad++; $display("FAIL underrun_duty_held: got %0d want 256", h); end
  endtask

  task automatic test_back_to_back();
    bit uni;
    int h, t, un;
    // Last clock of an empty frame: the transfer lands on the boundary itself.
    n_cmp++; if (sif.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_empty: got %b want 1", sif.in_ready); end
    sif.in_data  = 16'h4000;
    sif.in_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL b2b_boundary_underrun: got %b want 1", underrun); end
    n_cmp++; if (sif.in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_drop_a: got %b want 0", sif.in_ready); end
    sif.in_data = 16'h8000;
    measure(h, uni, t, un);
    n_cmp++; if (h != 256) begin n_bad++; $display("FAIL b2b_held_highs: got %0d want 256", h); end
    n_cmp++; if (sif.in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_at_b: got %b want 0", sif.in_ready); end
    @(negedge clk);
    n_cmp++; if (sif.in_ready !== 1'b1 || sample_tick !== 1'b1) begin
      n_bad++; $display("FAIL b2b_ready_rise: ready %b tick %b want 1 1", sif.in_ready, sample_tick);
    end
    fork
      measure(h, uni, t, un);
      begin
        @(negedge clk);
        n_cmp++; if (sif.in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_drop_b: got %b want 0", sif.in_ready); end
        sif.in_data = 16'hC000;
      end
    join
    n_cmp++; if (h != 256 || un != 0) begin n_bad++; $display("FAIL b2b_a_frame: highs %0d und %0d want 256 0", h, un); end
    @(negedge clk);
    n_cmp++; if (sif.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_rise_c: got %b want 1", sif.in_ready); end
    fork
      measure(h, uni, t, un);
      begin
        @(negedge clk);
        n_cmp++; if (sif.in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_drop_c: got %b want 0", sif.in_ready); end
        sif.in_valid = 1'b0;
      end
    join
    n_cmp++; if (h != 512 || un != 0) begin n_bad++; $display("FAIL b2b_b_frame: highs %0d und %0d want 512 0", h, un); end
    @(negedge clk);
    measure(h, uni, t, un);
    n_cmp++; if (h != 768 || un != 0) begin n_bad++; $display("FAIL b2b_c_frame: highs %0d und %0d want 768 0", h, un); end
  endtask

  task automatic test_enable();
    bit ok, uni;
    int cyc, h, t, un, ticks_off, und_off;
    push(16'hE000, ok);
    repeat (100) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL en_off_pwm: got %b want 0", pwm_out); end
    n_cmp++; if (sif.in_ready !== 1'b0) begin n_bad++; $display("FAIL en_off_ready: got %b want 0", sif.in_ready); end
    ticks_off = 0;
    und_off   = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      ticks_off += int'(sample_tick === 1'b1);
      und_off   += int'(underrun === 1'b1);
    end
    n_cmp++; if (ticks_off != 0 || und_off != 0) begin
      n_bad++; $display("FAIL en_off_events: ticks %0d und %0d want 0 0", ticks_off, und_off);
    end
    en = 1'b1;
    wait_tick(cyc);
    n_cmp++; if (cyc != 1024) begin n_bad++; $display("FAIL en_restart_tick: after %0d want 1024", cyc); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL en_buffer_retained: underrun %b want 0", underrun); end
    measure(h, uni, t, un);
    n_cmp++; if (h != 896) begin n_bad++; $display("FAIL en_retained_highs: got %0d want 896", h); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok, uni;
    int cyc, h, t, un;
    push(16'hF000, ok);
    repeat (300) @(negedge clk);
    n_cmp++; if (pwm_out !== 1'b1 || sif.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL pre_reset_state: pwm %b ready %b want 1 0", pwm_out, sif.in_ready);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (pwm_out !== 1'b0 || sample_tick !== 1'b0 || underrun !== 1'b0 || sif.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL async_reset_outputs: pwm %b tick %b und %b ready %b want 0 0 0 0",
                        pwm_out, sample_tick, underrun, sif.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_tick(cyc);
    n_cmp++; if (cyc != 1024) begin n_bad++; $display("FAIL post_reset_tick: after %0d want 1024", cyc); end
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL post_reset_underrun: got %b want 1", underrun); end
    measure(h, uni, t, un);
    n_cmp++; if (h != 0) begin n_bad++; $display("FAIL post_reset_highs: got %0d want 0", h); end
  endtask

`ifdef PWM_DITHER_EN
  task automatic test_dither();
    bit ok, uni;
    int h, t, un, n127, n128;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      fork
        measure(h, uni, t, un);
        push(16'hFFFF, ok);
      join
      if (i >= 1) begin
        n_cmp++; if (h != 1020) begin n_bad++; $display("FAIL dither_full_scale: got %0d want 1020", h); end
      end
      @(negedge clk);
    end
    n127 = 0;
    n128 = 0;
    for (int i = 0; i < 9; i++) begin
      fork
        measure(h, uni, t, un);
        push(16'h7F80, ok);
      join
      if (i >= 1) begin
        n127 += int'(h == 508);
        n128 += int'(h == 512);
        n_cmp++; if (h != 508 && h != 512) begin n_bad++; $display("FAIL dither_mid_duty: got %0d want 508 or 512", h); end
      end
      @(negedge clk);
    end
    n_cmp++; if (n127 == 0 || n128 == 0) begin
      n_bad++; $display("FAIL dither_toggle: duty127 frames %0d duty128 frames %0d want both nonzero", n127, n128);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_half_scale();
    test_zero_full();
    test_underrun();
    test_back_to_back();
    test_enable();
    test_reset_mid_frame();
`ifdef PWM_DITHER_EN
    test_dither();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
